// File: rtl/fetch_stage_mt_if.sv
// fetch_stage_mt_if: memory request/response and decode handshake bundle of the fetch stage
interface fetch_stage_mt_if #(
  parameter int NUM_THREADS = 4,
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
);
  localparam int TW = $clog2(NUM_THREADS);
  logic mem_req_valid;
  logic mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [7:0] mem_req_core;
  logic mem_rsp_valid;
  logic [INSN_W-1:0] mem_rsp_data;
  logic dec_valid;
  logic dec_ready;
  logic [TW-1:0] dec_thread;
  logic [ADDR_W-1:0] dec_pc;
  logic [INSN_W-1:0] dec_insn;
  logic dec_epoch;
  modport master (
    output mem_req_valid, mem_req_addr, mem_req_core, dec_valid, dec_thread, dec_pc, dec_insn, dec_epoch,
    input mem_req_ready, mem_rsp_valid, mem_rsp_data, dec_ready
  );
  modport slave (
    input mem_req_valid, mem_req_addr, mem_req_core, dec_valid, dec_thread, dec_pc, dec_insn, dec_epoch,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, dec_ready
  );
endinterface

// File: rtl/fetch_stage_mt.sv
// fetch_stage_mt: round-robin multithreaded instruction fetch with epoch-tagged redirects and output queue
module fetch_stage_mt #(
  parameter int CORE_ID = 0,
  parameter int NUM_THREADS = 4,
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic redir_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] redir_thread,
  input  logic [ADDR_W-1:0] redir_pc,
  fetch_stage_mt_if.master bus
);
  localparam int TW = $clog2(NUM_THREADS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int EW = TW + ADDR_W + INSN_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSN_W / 8);
  localparam logic [FW:0] FULL = (FW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc [NUM_THREADS];
  logic [NUM_THREADS-1:0] epoch;
  logic [TW-1:0] last_thread, cur_thread, next_thread;
  logic [ADDR_W-1:0] cur_pc;
  logic cur_epoch, any_en, push, pop;
  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0] count;
  // a response is kept only if no redirect touched its thread since issue, including this cycle
  assign push = state == WAIT && bus.mem_rsp_valid && cur_epoch == epoch[cur_thread] && !(redir_valid && redir_thread == cur_thread);
  assign pop = bus.dec_valid && bus.dec_ready;
  assign bus.mem_req_core = 8'(CORE_ID);
  assign bus.dec_valid = count != '0;
  assign {bus.dec_thread, bus.dec_pc, bus.dec_insn, bus.dec_epoch} = fifo[rd_ptr];
  // nearest enabled thread strictly after last_thread; descending loop lets the smallest offset win
  always_comb begin
    next_thread = last_thread;
    any_en = 1'b0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      if (thread_enable[last_thread + TW'(i)]) begin
        next_thread = last_thread + TW'(i);
        any_en = 1'b1;
      end
    end
  end
  // fetch FSM: pick a thread when a queue slot is free, hold the request until accepted, await the response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_thread <= TW'(NUM_THREADS - 1);
      cur_thread <= '0;
      cur_pc <= '0;
      cur_epoch <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr <= '0;
    end else begin
      case (state)
        IDLE: if (any_en && count < FULL) begin
          state <= REQ;
          last_thread <= next_thread;
          cur_thread <= next_thread;
          cur_pc <= pc[next_thread];
          cur_epoch <= epoch[next_thread];
          bus.mem_req_valid <= 1'b1;
          bus.mem_req_addr <= pc[next_thread];
        end
        REQ: if (bus.mem_req_ready) begin
          state <= WAIT;
          bus.mem_req_valid <= 1'b0;
        end
        WAIT: if (bus.mem_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // per-thread PC and epoch; a redirect is written last so it overrides a same-cycle advance
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) pc[i] <= RESET_PC;
      epoch <= '0;
    end else begin
      if (push) pc[cur_thread] <= cur_pc + STEP;
      if (redir_valid) begin
        pc[redir_thread] <= redir_pc;
        epoch[redir_thread] <= ~epoch[redir_thread];
      end
    end
  end
  // output queue; entries are cleared on reset so idle decode outputs read as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {cur_thread, cur_pc, bus.mem_rsp_data, cur_epoch};
        wr_ptr <= wr_ptr + FW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FW'(1);
      count <= count + (FW + 1)'(push) - (FW + 1)'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_stage_mt.sv
// tb_fetch_stage_mt: randomized bench against a transaction-level fetch model
module tb_fetch_stage_mt;
  localparam int NT = 4;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int FD = 4;
  localparam int TW = 2;
  localparam int CID = 5;
  localparam logic [AW-1:0] RPC = 32'h0;
  typedef struct {int t; logic [AW-1:0] pc; logic [IW-1:0] insn; bit ep;} pkt_t;
  logic clk = 1'b0;
  logic reset;
  logic [NT-1:0] thread_enable;
  logic redir_valid;
  logic [TW-1:0] redir_thread;
  logic [AW-1:0] redir_pc;
  fetch_stage_mt_if #(.NUM_THREADS(NT), .ADDR_W(AW), .INSN_W(IW)) bus ();
  fetch_stage_mt #(.CORE_ID(CID), .NUM_THREADS(NT), .ADDR_W(AW), .INSN_W(IW), .FIFO_DEPTH(FD), .RESET_PC(RPC)) dut (
    .clk(clk),
    .reset(reset),
    .thread_enable(thread_enable),
    .redir_valid(redir_valid),
    .redir_thread(redir_thread),
    .redir_pc(redir_pc),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [AW-1:0] m_pc [NT];
  bit m_ep [NT];
  int m_last, cap_t, delay;
  logic [AW-1:0] cap_pc, last_addr;
  bit cap_ep, busy, waiting;
  pkt_t q [$];
  int k_ready, k_dec, k_redir, k_stray, k_te, k_delay, k_reset_pm;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  // one clock: apply the edge just passed to the model, compare outputs, then drive new inputs
  task automatic cycle();
    int sz;
    bit got_rsp;
    @(negedge clk);
    got_rsp = 0;
    if (reset) begin
      for (int i = 0; i < NT; i++) begin
        m_pc[i] = RPC;
        m_ep[i] = 0;
      end
      m_last = NT - 1;
      busy = 0;
      waiting = 0;
      q.delete();
    end else begin
      sz = q.size();
      if (!busy) begin
        if (thread_enable != 0 && sz < FD) begin
          for (int k = 1; k <= NT; k++) begin
            if (thread_enable[(m_last + k) % NT]) begin
              cap_t = (m_last + k) % NT;
              break;
            end
          end
          m_last = cap_t;
          cap_pc = m_pc[cap_t];
          cap_ep = m_ep[cap_t];
          busy = 1;
        end
      end else if (!waiting) begin
        if (bus.mem_req_ready) begin
          waiting = 1;
          delay = $urandom_range(k_delay, 0);
        end
      end else if (bus.mem_rsp_valid) begin
        busy = 0;
        waiting = 0;
        got_rsp = 1;
      end
      if (sz > 0 && bus.dec_ready) void'(q.pop_front());
      if (got_rsp && cap_ep == m_ep[cap_t] && !(redir_valid && redir_thread == cap_t)) begin
        q.push_back('{cap_t, cap_pc, bus.mem_rsp_data, cap_ep});
        m_pc[cap_t] = cap_pc + 32'd4;
      end
      if (redir_valid) begin
        m_pc[redir_thread] = redir_pc;
        m_ep[redir_thread] = !m_ep[redir_thread];
      end
    end
    check("req_valid", bus.mem_req_valid, busy && !waiting);
    if (busy && !waiting) check("req_addr", bus.mem_req_addr, cap_pc);
    if (bus.mem_req_valid) last_addr = bus.mem_req_addr;
    check("req_core", bus.mem_req_core, CID);
    check("dec_valid", bus.dec_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("dec_thread", bus.dec_thread, q[0].t);
      check("dec_pc", bus.dec_pc, q[0].pc);
      check("dec_insn", bus.dec_insn, q[0].insn);
      check("dec_epoch", bus.dec_epoch, q[0].ep);
    end
    if (reset) begin
      check("rst_addr", bus.mem_req_addr, 0);
      check("rst_thread", bus.dec_thread, 0);
      check("rst_pc", bus.dec_pc, 0);
      check("rst_insn", bus.dec_insn, 0);
      check("rst_epoch", bus.dec_epoch, 0);
    end
    reset = $urandom_range(999, 0) < k_reset_pm;
    if ($urandom_range(99, 0) < k_te) thread_enable = NT'($urandom);
    redir_valid = $urandom_range(99, 0) < k_redir;
    redir_thread = TW'($urandom);
    redir_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(1023, 0)) << 2;
    bus.mem_req_ready = $urandom_range(99, 0) < k_ready;
    if (waiting && delay == 0) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data = mem_word(last_addr);
    end else begin
      if (waiting) delay--;
      bus.mem_rsp_valid = !waiting && $urandom_range(99, 0) < k_stray;
      bus.mem_rsp_data = $urandom;
    end
    bus.dec_ready = $urandom_range(99, 0) < k_dec;
  endtask
  initial begin
    reset = 1'b1;
    thread_enable = 4'b0001;
    redir_valid = 1'b0;
    redir_thread = '0;
    redir_pc = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    bus.dec_ready = 1'b1;
    k_ready = 100; k_dec = 100; k_redir = 0; k_stray = 0; k_te = 0; k_delay = 0; k_reset_pm = 0;
    cycle();
    repeat (12) cycle();
    thread_enable = 4'b1111;
    repeat (30) cycle();
    k_dec = 0;
    repeat (25) cycle();
    k_dec = 100;
    cycle();
    k_dec = 0;
    repeat (10) cycle();
    k_dec = 100;
    repeat (5) cycle();
    k_ready = 60; k_dec = 60; k_redir = 8; k_stray = 10; k_te = 5; k_delay = 3; k_reset_pm = 3;
    repeat (3000) cycle();
    k_ready = 100; k_dec = 100; k_redir = 0; k_te = 0; k_reset_pm = 0; k_stray = 0;
    thread_enable = 4'b1111;
    for (int i = 0; i < 50 && !waiting; i++) cycle();
    check("reach_wait", waiting, 1'b1);
    reset = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    thread_enable = '0;
    k_stray = 100;
    cycle();
    repeat (5) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage_mt.md
FETCH_STAGE_MT -- requirements
Module: fetch_stage_mt

Interface
REQ-001 Parameter CORE_ID, default 0, core index driven on mem_req_core.
REQ-002 Parameter NUM_THREADS, default 4, hardware thread contexts (>=2, power of 2).
REQ-003 Parameter ADDR_W, default 32, PC/address width.
REQ-004 Parameter INSN_W, default 32, instruction width (multiple of 8).
REQ-005 Parameter FIFO_DEPTH, default 4, output queue entries (power of 2, >=2).
REQ-006 Parameter RESET_PC, default 0, reset PC of every thread.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  clock, all state updates on rising edge.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 thread_enable  in  NUM_THREADS  per-thread fetch enable mask.
REQ-011 redir_valid / redir_thread / redir_pc  in  1 / log2(NUM_THREADS) / ADDR_W  store-stage PC redirect.
REQ-012 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-013 mem_req_addr / mem_req_core  out  ADDR_W / 8  fetch address, CORE_ID.
REQ-014 mem_rsp_valid / mem_rsp_data  in  1 / INSN_W  memory response (one per request, in order).
REQ-015 dec_valid / dec_ready  out / in  1 / 1  decode handshake.
REQ-016 dec_thread / dec_pc / dec_insn / dec_epoch  out  log2(NUM_THREADS) / ADDR_W / INSN_W / 1  fetched packet.

Function
REQ-017 FSM states IDLE, REQ, WAIT; at most one memory request outstanding.
REQ-018 IDLE: if any thread_enable bit set and fifo_count < FIFO_DEPTH, select next enabled thread round-robin strictly after last_thread (wrap), capture its PC and epoch, go REQ; else stay IDLE.
REQ-019 REQ: mem_req_valid=1, mem_req_addr=captured PC, held stable until mem_req_ready; transfer cycle -> WAIT.
REQ-020 WAIT: on mem_rsp_valid, if captured epoch equals current thread epoch, push {thread, PC, data, epoch} and set pc[t] = PC + INSN_W/8 (mod 2^ADDR_W); else drop response, PC unchanged; -> IDLE.
REQ-021 mem_rsp_valid outside WAIT is ignored.
REQ-022 redir_valid: pc[redir_thread] <= redir_pc, epoch[redir_thread] toggles, same cycle.
REQ-023 Redirect and response for same thread in same cycle: response treated as stale (dropped), redirect PC wins.
REQ-024 Redirect while that thread is in REQ: request still completes handshake; its response dropped.
REQ-025 FIFO entries already queued are not flushed; decode filters by dec_epoch.
REQ-026 dec_valid = fifo non-empty; pop on dec_valid & dec_ready; outputs show head entry.
REQ-027 Simultaneous push and pop: count unchanged; push into full FIFO impossible (slot checked at issue, only one outstanding).
REQ-028 Thread disabled after selection: in-flight fetch completes normally.
REQ-029 Latency: IDLE->REQ 1 cycle; best-case issue to dec_valid = 2 cycles after response cycle's edge (push registered, visible next cycle).
REQ-030 Throughput: at most one fetch per 3 cycles with zero-latency memory.

Reset
REQ-031 On reset: state IDLE, all pc = RESET_PC, all epoch = 0, last_thread = NUM_THREADS-1, FIFO empty.
REQ-032 Reset outputs: mem_req_valid=0, dec_valid=0, mem_req_addr=0, dec_* data=0.
REQ-033 Reset mid-REQ/WAIT abandons transaction; subsequent stray mem_rsp_valid ignored.

Verification
REQ-034 Reset, thread_enable=4'b0001, mem ready/respond next cycle -> dec_pc sequence 0,4,8 on thread 0, epoch 0.
REQ-035 thread_enable=4'b1111 -> dec_thread order 0,1,2,3,0 each PC 0 then 4.
REQ-036 Redirect thread 1 to 0x100 during its WAIT -> that response dropped; next thread-1 packet pc=0x100, epoch=1.
REQ-037 dec_ready=0 -> after 4 pushes dec_valid=1, no further mem_req_valid; one pop -> exactly one new request.
REQ-038 mem_req_ready low 5 cycles -> mem_req_addr stable, single transfer.
REQ-039 PC 0xFFFFFFFC fetch -> next pc 0x00000000; reset asserted in WAIT -> outputs per REQ-032 next cycle.
